// File: rtl/univ_shift_reg_p.sv
// Universal shift register with single-step and counted multi-step operation.
// A multi-step request latches the operation and step count, then applies the
// operation once per cycle until the count is exhausted, pulsing done at the end.
module univ_shift_reg_p #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] out,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       opMode_q, opMode_d;
    logic             done_q, done_d;

    // One application of an operation to the current contents. Hold, reserved
    // and anything unrecognised leave the value untouched.
    function automatic logic [WIDTH-1:0] applyOp(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic             sMsb,
        input logic             sLsb,
        input logic [WIDTH-1:0] par
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (op)
            MODE_SHR:  res = {sMsb, cur[WIDTH-1:1]};
            MODE_SHL:  res = {cur[WIDTH-2:0], sLsb};
            MODE_LOAD: res = par;
            MODE_ROR:  res = {cur[0], cur[WIDTH-1:1]};
            MODE_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default:   res = cur;
        endcase
        return res;
    endfunction

    // Only genuine shifting/rotating operations can be repeated; hold, load
    // and reserved requests fall through to the single-step path instead.
    function automatic logic isMultiStep(input logic [2:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR: ok = 1'b1;
            MODE_HOLD, MODE_LOAD:                              ok = 1'b0;
            default:                                           ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Next-state logic: accept requests in IDLE, count down steps in RUN.
    // A zero-step request still spends one cycle in RUN so done always
    // follows acceptance by at least two edges.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        count_d  = count_q;
        opMode_d = opMode_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && isMultiStep(mode)) begin
                    opMode_d = mode;
                    count_d  = amount;
                    state_d  = RUN;
                end else if (en) begin
                    out_d = applyOp(mode, out_q, sin_msb, sin_lsb, pin);
                end
            end
            RUN: begin
                if (count_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    out_d   = applyOp(opMode_q, out_q, sin_msb, sin_lsb, pin);
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset that wins over
    // everything, aborting any operation in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            out_q    <= '0;
            count_q  <= '0;
            opMode_q <= MODE_HOLD;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            count_q  <= count_d;
            opMode_q <= opMode_d;
            done_q   <= done_d;
        end
    end

    assign out      = out_q;
    assign sout_lsb = out_q[0];
    assign sout_msb = out_q[WIDTH-1];
    assign busy     = (state_q == RUN);
    assign done     = done_q;

endmodule

// File: tb/tb_univ_shift_reg_p.sv
// Self-checking bench for univ_shift_reg_p (WIDTH=8): directed scenarios
// followed by random traffic, all compared against a behavioural model.
module tb_univ_shift_reg_p;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic       sin_msb;
    logic       sin_lsb;
    logic [7:0] pin;
    logic       start;
    logic [3:0] amount;
    logic [7:0] out;
    logic       sout_lsb;
    logic       sout_msb;
    logic       busy;
    logic       done;

    int total;
    int bad;

    // Reference model state: contents, whether a counted operation is active,
    // how many shifts remain, how many RUN cycles remain, and the done flag.
    int       mOut;
    bit       mRun;
    int       mShiftsLeft;
    int       mCyclesLeft;
    int       mMode;
    bit       mDone;

    univ_shift_reg_p #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .sin_msb  (sin_msb),
        .sin_lsb  (sin_lsb),
        .pin      (pin),
        .start    (start),
        .amount   (amount),
        .out      (out),
        .sout_lsb (sout_lsb),
        .sout_msb (sout_msb),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One operation on an 8-bit value expressed with integer arithmetic.
    function automatic int refOp(input int m, input int v, input int sMsb,
                                 input int sLsb, input int p);
        case (m)
            1: return v / 2 + sMsb * 128;
            2: return (v * 2) % 256 + sLsb;
            3: return p;
            4: return v / 2 + (v % 2) * 128;
            5: return (v * 2) % 256 + v / 128;
            6: return v / 2 + ((v >= 128) ? 128 : 0);
            default: return v;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic modelStep();
        if (rst === 1'b0) begin
            mOut = 0; mRun = 0; mShiftsLeft = 0; mCyclesLeft = 0; mDone = 0;
        end else if (!mRun) begin
            mDone = 0;
            if (start && (mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
                mMode       = int'(mode);
                mShiftsLeft = int'(amount);
                mCyclesLeft = (amount == 0) ? 1 : int'(amount);
                mRun        = 1;
            end else if (en) begin
                mOut = refOp(int'(mode), mOut, int'(sin_msb), int'(sin_lsb), int'(pin));
            end
        end else begin
            if (mShiftsLeft > 0) begin
                mOut = refOp(mMode, mOut, int'(sin_msb), int'(sin_lsb), 0);
                mShiftsLeft--;
            end
            mCyclesLeft--;
            if (mCyclesLeft == 0) begin
                mRun  = 0;
                mDone = 1;
            end
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkOutput(input string tag);
        checkVal({tag, ".out"},  32'(out),      32'(mOut));
        checkVal({tag, ".slsb"}, 32'(sout_lsb), 32'(mOut % 2));
        checkVal({tag, ".smsb"}, 32'(sout_msb), 32'(mOut / 128));
        checkVal({tag, ".busy"}, 32'(busy),     32'(mRun));
        checkVal({tag, ".done"}, 32'(done),     32'(mDone));
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic s,
                                 input logic [2:0] m, input logic [3:0] a,
                                 input logic [7:0] p, input logic sm, input logic sl);
        rst = r; en = e; start = s; mode = m; amount = a; pin = p;
        sin_msb = sm; sin_lsb = sl;
    endtask

    // Model the edge, let it happen, then sample 1 time unit later.
    task automatic tick(input string tag);
        modelStep();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        total = 0; bad = 0;
        mOut = 0; mRun = 0; mShiftsLeft = 0; mCyclesLeft = 0; mMode = 0; mDone = 0;
        applyStimulus(1'b0, 1'b1, 1'b1, 3'b101, 4'd3, 8'hFF, 1'b1, 1'b1);
        @(negedge clk);

        // Reset dominates start and en.
        tick("rst0");
        tick("rst1");
        checkVal("rstOut", 32'(out), 32'h00);
        checkVal("rstBusy", 32'(busy), 32'h0);

        // Parallel load then right shifts with sin_msb=1.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b011, 4'd0, 8'hA5, 1'b0, 1'b0);
        tick("load");
        checkVal("loadA5", 32'(out), 32'hA5);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b001, 4'd0, 8'h00, 1'b1, 1'b0);
        tick("shr1");
        checkVal("shrD2", 32'(out), 32'hD2);
        tick("shr2");
        checkVal("shrE9", 32'(out), 32'hE9);
        tick("shr3");
        checkVal("shrF4", 32'(out), 32'hF4);

        // Rotate left by 3 from 81.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b011, 4'd0, 8'h81, 1'b0, 1'b0);
        tick("load81");
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b101, 4'd3, 8'h00, 1'b0, 1'b0);
        tick("rolAcc");
        checkVal("rolAccOut", 32'(out), 32'h81);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        tick("rol1");
        checkVal("rol03", 32'(out), 32'h03);
        tick("rol2");
        checkVal("rol06", 32'(out), 32'h06);
        tick("rol3");
        checkVal("rol0C", 32'(out), 32'h0C);
        checkVal("rolDone", 32'(done), 32'h1);
        checkVal("rolBusyLow", 32'(busy), 32'h0);
        tick("rolPost");
        checkVal("rolDoneOnce", 32'(done), 32'h0);

        // Arithmetic shift by 9 from 80, with noise on ignored inputs.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b011, 4'd0, 8'h80, 1'b0, 1'b0);
        tick("load80");
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b110, 4'd9, 8'h00, 1'b0, 1'b0);
        tick("asrAcc");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'($urandom), 1'($urandom), 3'($urandom), 4'($urandom),
                          8'($urandom), 1'($urandom), 1'($urandom));
            tick("asrRun");
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        tick("asrLast");
        checkVal("asrFF", 32'(out), 32'hFF);
        checkVal("asrDone", 32'(done), 32'h1);

        // Zero-amount start, then back-to-back start in the done cycle.
        applyStimulus(1'b1, 1'b1, 1'b1, 3'b001, 4'd0, 8'h00, 1'b0, 1'b0);
        tick("zeroAcc");
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        tick("zeroRun");
        checkVal("zeroDone", 32'(done), 32'h1);
        checkVal("zeroOut", 32'(out), 32'hFF);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 4'd2, 8'h00, 1'b0, 1'b0);
        tick("b2bAcc");
        checkVal("b2bBusy", 32'(busy), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        tick("b2b1");
        tick("b2b2");
        checkVal("b2bOut", 32'(out), 32'hFC);

        // Reset in the middle of a rotate aborts it silently.
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b100, 4'd5, 8'h00, 1'b0, 1'b0);
        tick("rorAcc");
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        tick("ror1");
        tick("ror2");
        applyStimulus(1'b0, 1'b1, 1'b1, 3'b100, 4'd5, 8'h00, 1'b0, 1'b0);
        tick("abort");
        checkVal("abortOut", 32'(out), 32'h00);
        checkVal("abortBusy", 32'(busy), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick("postAbort");
        end

        $display("[TB] random phase");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                          3'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
